demux1x2_reg: RTL and testbench

- Registered 1-to-2 demultiplexer: the write-side counterpart of the 4-bit 2:1 selector in the ALU/register-file datapath.
- Steers one WIDTH-bit result stream to one of two destination channels, a or b, chosen by in_sel.
- Each channel has a one-entry output holding register with a valid/ready handshake, so the ALU result path and the register-file write ports are decoupled.
- Per-channel flow control: a stalled channel blocks only transfers addressed to it.

---
 rtl/demux1x2_reg.sv | 99 +++++++++
 tb/tb_demux1x2_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry valid/ready holding register per channel.
// Optional per-channel transfer counters are enabled with `define DEMUX1X2_CNT_EN.
//
// state | meaning
// EMPTY | channel holding register has no data (x_valid=0)
// FULL  | channel holding register presents data (x_valid=1)
module demux1x2_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX1X2_CNT_EN
    ,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t a_state, a_state_next;
    chan_state_t b_state, b_state_next;
    logic        accept;
    logic        load_a;
    logic        load_b;

    assign a_valid = (a_state == FULL);
    assign b_valid = (b_state == FULL);

    // Readiness looks only at the addressed channel, so a stalled channel never blocks the other.
    assign in_ready = in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready);
    assign accept   = in_valid & in_ready;
    assign load_a   = accept & ~in_sel;
    assign load_b   = accept & in_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
        end else begin
            a_state <= a_state_next;
            b_state <= b_state_next;
        end
    end

    always_comb begin
        a_state_next = a_state;
        case (a_state)
            EMPTY:   if (load_a) a_state_next = FULL;
            FULL:    if (a_ready && !load_a) a_state_next = EMPTY;
            default: a_state_next = EMPTY;
        endcase
    end

    always_comb begin
        b_state_next = b_state;
        case (b_state)
            EMPTY:   if (load_b) b_state_next = FULL;
            FULL:    if (b_ready && !load_b) b_state_next = EMPTY;
            default: b_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (load_a) a_data <= in_data;
            if (load_b) b_data <= in_data;
        end
    end

`ifdef DEMUX1X2_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (load_a && (a_count != 8'hFF)) a_count <= a_count + 8'd1;
            if (load_b && (b_count != 8'hFF)) b_count <= b_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2_reg.sv
// Testbench for demux1x2_reg: directed vector table, corner sequences and random traffic
// compared against a queue-based channel model.
module tb_demux1x2_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
`ifdef DEMUX1X2_CNT_EN
    logic [7:0]       a_count;
    logic [7:0]       b_count;
`endif

    demux1x2_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX1X2_CNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel is a FIFO of capacity one; counters saturate at 255.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    int               cnt_a = 0;
    int               cnt_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic check_outputs_vs_model();
        chk("model_a_valid", int'(a_valid), int'(qa.size() != 0));
        chk("model_b_valid", int'(b_valid), int'(qb.size() != 0));
        if (qa.size() != 0) chk("model_a_data", int'(a_data), int'(qa[0]));
        if (qb.size() != 0) chk("model_b_data", int'(b_data), int'(qb[0]));
`ifdef DEMUX1X2_CNT_EN
        chk("model_a_count", int'(a_count), cnt_a);
        chk("model_b_count", int'(b_count), cnt_b);
`endif
    endtask

    // One cycle: drive inputs after the falling edge, check in_ready, clock, then check outputs.
    task automatic step(input logic [WIDTH-1:0] d, input logic sel, input logic v,
                        input logic ar, input logic br);
        logic exp_ready;
        logic acc;
        @(negedge clk);
        in_data  = d;
        in_sel   = sel;
        in_valid = v;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_ready = sel ? ((qb.size() == 0) || br) : ((qa.size() == 0) || ar);
        chk("model_in_ready", int'(in_ready), int'(exp_ready));
        acc = v & exp_ready;
        @(posedge clk);
        if ((qa.size() != 0) && ar) void'(qa.pop_front());
        if ((qb.size() != 0) && br) void'(qb.pop_front());
        if (acc && !sel) begin
            qa.push_back(d);
            if (cnt_a < 255) cnt_a++;
        end
        if (acc && sel) begin
            qb.push_back(d);
            if (cnt_b < 255) cnt_b++;
        end
        #1;
        check_outputs_vs_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             sel;
        logic             v;
        logic             ar;
        logic             br;
        logic             exp_ready;
        logic             exp_av;
        logic [WIDTH-1:0] exp_ad;
        logic             exp_bv;
        logic [WIDTH-1:0] exp_bd;
    } vec_t;

    vec_t vecs[14];

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        //        d     sel   v     ar    br    rdy   av    ad    bv    bd
        vecs[0]  = '{4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0};
        vecs[1]  = '{4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h3};
        vecs[2]  = '{4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h3};
        vecs[3]  = '{4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 4'h3};
        vecs[4]  = '{4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 4'h0};
        vecs[5]  = '{4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0};
        vecs[6]  = '{4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0};
        vecs[7]  = '{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0};
        vecs[8]  = '{4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 4'h0};
        vecs[9]  = '{4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
        vecs[10] = '{4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h6};
        vecs[11] = '{4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h8, 1'b0, 4'h0};
        vecs[12] = '{4'hE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h8, 1'b1, 4'hE};
        vecs[13] = '{4'hD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hD};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_a_valid", int'(a_valid), 0);
        chk("reset_b_valid", int'(b_valid), 0);
        chk("reset_a_data", int'(a_data), 0);
        chk("reset_b_data", int'(b_data), 0);

        // Directed table: expectations written out by hand.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_data  = vecs[i].d;
            in_sel   = vecs[i].sel;
            in_valid = vecs[i].v;
            a_ready  = vecs[i].ar;
            b_ready  = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_ready));
            begin
                logic acc;
                acc = vecs[i].v & vecs[i].exp_ready;
                @(posedge clk);
                if ((qa.size() != 0) && vecs[i].ar) void'(qa.pop_front());
                if ((qb.size() != 0) && vecs[i].br) void'(qb.pop_front());
                if (acc && !vecs[i].sel) begin qa.push_back(vecs[i].d); if (cnt_a < 255) cnt_a++; end
                if (acc &&  vecs[i].sel) begin qb.push_back(vecs[i].d); if (cnt_b < 255) cnt_b++; end
            end
            #1;
            chk($sformatf("vec%0d_a_valid", i), int'(a_valid), int'(vecs[i].exp_av));
            chk($sformatf("vec%0d_b_valid", i), int'(b_valid), int'(vecs[i].exp_bv));
            if (vecs[i].exp_av) chk($sformatf("vec%0d_a_data", i), int'(a_data), int'(vecs[i].exp_ad));
            if (vecs[i].exp_bv) chk($sformatf("vec%0d_b_data", i), int'(b_data), int'(vecs[i].exp_bd));
        end

        // Backpressure: a holds 4'hC for 5 cycles of further sel=0 traffic.
        step(4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            chk("stall_a_data", int'(a_data), 12);
            chk("stall_a_valid", int'(a_valid), 1);
        end

        // Asynchronous reset in the middle of a cycle with a_valid=1.
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("async_reset_a_valid", int'(a_valid), 0);
        chk("async_reset_b_valid", int'(b_valid), 0);
        chk("async_reset_a_data", int'(a_data), 0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end

`ifdef DEMUX1X2_CNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) step(4'(i), 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(4'(i), 1'b0, 1'b1, 1'b1, 1'b1);
        chk("sat_b_count", int'(b_count), 255);
        chk("sat_a_count", int'(a_count), 2);
        do_reset();
        #1;
        chk("reset_a_count", int'(a_count), 0);
        chk("reset_b_count", int'(b_count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
